// File: rtl/wb_write_arbiter_if.sv
// Write-back port bundle: pipeline and MDU producers in, register-file write port and hazard status out.
// The arbiter takes the slave side; the producer/register-file/hazard environment takes the master side.
interface wb_write_arbiter_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              pipe_we;
    logic [4:0]        pipe_rd;
    logic [DATA_W-1:0] pipe_wd;

    logic              mdu_valid;
    logic [4:0]        mdu_rd;
    logic [DATA_W-1:0] mdu_wd;
    logic              mdu_ready;

    logic              wr_en;
    logic [4:0]        a3;
    logic [DATA_W-1:0] wd;

    logic [31:0]       pend_mask;
    logic [CNT_W-1:0]  fifo_count;
    logic              stall_req;

    modport master (
        output pipe_we, pipe_rd, pipe_wd,
        output mdu_valid, mdu_rd, mdu_wd,
        input  mdu_ready,
        input  wr_en, a3, wd,
        input  pend_mask, fifo_count, stall_req
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_wd,
        input  mdu_valid, mdu_rd, mdu_wd,
        output mdu_ready,
        output wr_en, a3, wd,
        output pend_mask, fifo_count, stall_req
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges pipeline write-back and queued MDU results onto the single register-file write port.
// Latency: pipeline write 1 clk to wr_en; MDU result >= 2 clk (enqueue, then pop into an idle slot).
// Backpressure: mdu_ready drops while the FIFO is full; the pipeline is never stalled, only asked via stall_req.
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    wb_write_arbiter_if.slave  io_wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(STARVE_MAX + 1);

    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_ONE   = {{(AGE_W-1){1'b0}}, 1'b1};
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_MAX);

    logic [4:0]        r_rd  [DEPTH];
    logic [DATA_W-1:0] r_dat [DEPTH];
    logic [DEPTH-1:0]  r_live;
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CNT_W-1:0]  r_count;

    logic              r_wr_en;
    logic [4:0]        r_a3;
    logic [DATA_W-1:0] r_wd;
    logic [31:0]       r_pend;
    logic [AGE_W-1:0]  r_age;

    logic              w_pipe_act;
    logic              w_empty;
    logic              w_ready;
    logic              w_push;
    logic              w_push_live;
    logic              w_pop;
    logic              w_head_live;
    logic              w_head_kill;
    logic [DEPTH-1:0]  w_live_nxt;
    logic [31:0]       w_pend_nxt;
    logic [4:0]        w_slot_rd;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [AGE_W-1:0]  w_age_nxt;

    // Writes to x0 are architecturally void, so rd==0 is treated as no request on both sides.
    assign w_pipe_act  = io_wb.pipe_we && (io_wb.pipe_rd != 5'd0);
    assign w_empty     = (r_count == '0);
    assign w_ready     = (r_count != CNT_FULL);
    assign w_push      = io_wb.mdu_valid && w_ready && (io_wb.mdu_rd != 5'd0);
    assign w_push_live = !(w_pipe_act && (io_wb.mdu_rd == io_wb.pipe_rd));
    assign w_pop       = !w_pipe_act && !w_empty;
    assign w_head_live = !w_empty && r_live[r_rp];
    assign w_head_kill = w_pipe_act && w_head_live && (r_rd[r_rp] == io_wb.pipe_rd);

    // Free slots always hold live=0, so the kill sweep and the mask OR can scan every slot.
    always_comb begin
        w_live_nxt = r_live;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_pipe_act && (r_rd[i] == io_wb.pipe_rd)) begin
                w_live_nxt[i] = 1'b0;
            end
            if (w_pop && (r_rp == PTR_W'(i))) begin
                w_live_nxt[i] = 1'b0;
            end
            if (w_push && (r_wp == PTR_W'(i))) begin
                w_live_nxt[i] = w_push_live;
            end
        end
    end

    always_comb begin
        w_pend_nxt = '0;
        w_slot_rd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot_rd = (w_push && (r_wp == PTR_W'(i))) ? io_wb.mdu_rd : r_rd[i];
            if (w_live_nxt[i]) begin
                w_pend_nxt[w_slot_rd] = 1'b1;
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_comb begin
        w_age_nxt = '0;
        if (w_head_live && !w_pop && !w_head_kill) begin
            w_age_nxt = (r_age >= AGE_LIMIT) ? AGE_LIMIT : r_age + AGE_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wp]  <= io_wb.mdu_rd;
            r_dat[r_wp] <= io_wb.mdu_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live  <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_pend  <= '0;
            r_age   <= '0;
        end else begin
            r_live  <= w_live_nxt;
            r_count <= w_count_nxt;
            r_pend  <= w_pend_nxt;
            r_age   <= w_age_nxt;
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end
        end
    end

    // A killed head still consumes its slot but produces no write; a3/wd keep their last values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en <= 1'b0;
            r_a3    <= '0;
            r_wd    <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_pipe_act) begin
                r_wr_en <= 1'b1;
                r_a3    <= io_wb.pipe_rd;
                r_wd    <= io_wb.pipe_wd;
            end else if (w_pop && w_head_live) begin
                r_wr_en <= 1'b1;
                r_a3    <= r_rd[r_rp];
                r_wd    <= r_dat[r_rp];
            end
        end
    end

    assign io_wb.mdu_ready  = w_ready;
    assign io_wb.wr_en      = r_wr_en;
    assign io_wb.a3         = r_a3;
    assign io_wb.wd         = r_wd;
    assign io_wb.pend_mask  = r_pend;
    assign io_wb.fifo_count = r_count;
    assign io_wb.stall_req  = (r_age >= AGE_LIMIT);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int DEPTH      = 4;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_write_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    wb_write_arbiter #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_wb (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
        bit          live;
    } ent_t;

    ent_t        q[$];
    bit          m_wr_en = 1'b0;
    logic [4:0]  m_a3    = '0;
    logic [31:0] m_wd    = '0;
    int          m_age   = 0;
    logic [31:0] m_rf [32];
    logic [31:0] rf   [32];

    int n_chk  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    // Register file sink: consumes the write port on the negedge after it is presented.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) rf[bus.a3] <= bus.wd;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en",      {31'd0, bus.wr_en},     {31'd0, m_wr_en});
            chk("a3",         {27'd0, bus.a3},        {27'd0, m_a3});
            chk("wd",         bus.wd,                 m_wd);
            chk("fifo_count", 32'(bus.fifo_count),    32'(q.size()));
            chk("pend_mask",  bus.pend_mask,          model_pend());
            chk("mdu_ready",  {31'd0, bus.mdu_ready}, {31'd0, q.size() < DEPTH});
            chk("stall_req",  {31'd0, bus.stall_req}, {31'd0, m_age >= STARVE_MAX});
        end
    end

    task automatic drive(bit pe, logic [4:0] prd, logic [31:0] pwd,
                         bit mv, logic [4:0] mrd, logic [31:0] mwd);
        bus.pipe_we   = pe;
        bus.pipe_rd   = prd;
        bus.pipe_wd   = pwd;
        bus.mdu_valid = mv;
        bus.mdu_rd    = mrd;
        bus.mdu_wd    = mwd;
    endtask

    // One clock: drive inputs, then advance the model across the edge and return just after it.
    task automatic cyc(bit pe, logic [4:0] prd, logic [31:0] pwd,
                       bit mv, logic [4:0] mrd, logic [31:0] mwd);
        bit   pact, push, pop, hkill;
        int   nage;
        ent_t h;
        drive(pe, prd, pwd, mv, mrd, mwd);
        @(posedge clk);
        pact  = pe && (prd != 5'd0);
        push  = mv && (q.size() < DEPTH) && (mrd != 5'd0);
        pop   = !pact && (q.size() > 0);
        hkill = 1'b0;
        nage  = 0;
        if (q.size() > 0) begin
            hkill = pact && q[0].live && (q[0].rd == prd);
            if (q[0].live && !pop && !hkill) nage = (m_age + 1 > STARVE_MAX) ? STARVE_MAX : m_age + 1;
        end
        m_age = nage;
        if (pact) begin
            m_wr_en = 1'b1;
            m_a3    = prd;
            m_wd    = pwd;
            m_rf[prd] = pwd;
            foreach (q[i]) if (q[i].rd == prd) q[i].live = 1'b0;
        end else if (pop) begin
            h = q.pop_front();
            m_wr_en = h.live;
            if (h.live) begin
                m_a3 = h.rd;
                m_wd = h.wd;
                m_rf[h.rd] = h.wd;
            end
        end else begin
            m_wr_en = 1'b0;
        end
        if (push) q.push_back('{mrd, mwd, !(pact && (mrd == prd))});
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        q.delete();
        m_wr_en = 1'b0;
        m_a3    = '0;
        m_wd    = '0;
        m_age   = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]   = '0;
            m_rf[i] = '0;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_ready", {31'd0, bus.mdu_ready}, 32'd1);
        chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);

        // Mid-stream reset with three results queued.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 5'd7, 32'h7000 + i, 1'b1, 5'(i), 32'h100 + i);
        chk("q3_count", 32'(bus.fifo_count), 32'd3);
        chk("q3_pend", bus.pend_mask, 32'h0000_000E);
        chk("model_q3", 32'(q.size()), 32'd3);
        do_reset();
        chk("midrst_count", 32'(bus.fifo_count), 32'd0);
        chk("midrst_pend", bus.pend_mask, 32'd0);
        chk("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("midrst_ready", {31'd0, bus.mdu_ready}, 32'd1);

        // Pipeline wins the slot; the MDU result follows in the next idle slot.
        cyc(1'b1, 5'd5, 32'hAAAA_0001, 1'b1, 5'd6, 32'h1234);
        chk("prio_wr_en", {31'd0, bus.wr_en}, 32'd1);
        chk("prio_a3", {27'd0, bus.a3}, 32'd5);
        chk("prio_wd", bus.wd, 32'hAAAA_0001);
        chk("prio_pend", bus.pend_mask, 32'h0000_0040);
        idle();
        chk("drain_a3", {27'd0, bus.a3}, 32'd6);
        chk("drain_wd", bus.wd, 32'h1234);
        chk("drain_pend", bus.pend_mask, 32'd0);

        // Fill to full under continuous pipeline writes, then reject a fifth result.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 5'd7, 32'h7700 + i, 1'b1, 5'(i), 32'hB00 + i);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_ready", {31'd0, bus.mdu_ready}, 32'd0);
        chk("full_pend", bus.pend_mask, 32'h0000_001E);
        cyc(1'b1, 5'd7, 32'h7705, 1'b1, 5'd5, 32'hB05);
        chk("reject_count", 32'(bus.fifo_count), 32'd4);
        chk("reject_pend", bus.pend_mask, 32'h0000_001E);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hB05);
        chk("pop1_a3", {27'd0, bus.a3}, 32'd1);
        chk("pop1_wd", bus.wd, 32'hB01);
        chk("pop1_count", 32'(bus.fifo_count), 32'd3);
        chk("pop1_ready", {31'd0, bus.mdu_ready}, 32'd1);
        repeat (3) idle();
        chk("empty_a3", {27'd0, bus.a3}, 32'd4);
        chk("empty_count", 32'(bus.fifo_count), 32'd0);

        // WAW: a younger pipeline write to x9 kills the queued MDU result.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55);
        chk("waw_pend_set", bus.pend_mask, 32'h0000_0200);
        cyc(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'd0);
        chk("waw_pend_clr", bus.pend_mask, 32'd0);
        chk("waw_count", 32'(bus.fifo_count), 32'd1);
        idle();
        chk("waw_kill_slot", {31'd0, bus.wr_en}, 32'd0);
        chk("waw_kill_count", 32'(bus.fifo_count), 32'd0);
        @(negedge clk);
        #1;
        chk("rf_x9", rf[9], 32'h77);
        chk("rf_x5", rf[5], 32'hAAAA_0001);
        chk("rf_x6", rf[6], 32'h1234);

        // x0 on both producers is ignored.
        cyc(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
        chk("x0_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("x0_count", 32'(bus.fifo_count), 32'd0);
        chk("x0_pend", bus.pend_mask, 32'd0);

        // Starvation: head blocked by ten pipeline writes, then one free slot drains it.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h333);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 5'd7, 32'h7000 + k, 1'b0, 5'd0, 32'd0);
            if (k == 7)  chk("starve_k7", {31'd0, bus.stall_req}, 32'd0);
            if (k == 8)  chk("starve_k8", {31'd0, bus.stall_req}, 32'd1);
            if (k == 10) chk("starve_k10", {31'd0, bus.stall_req}, 32'd1);
        end
        idle();
        chk("starve_a3", {27'd0, bus.a3}, 32'd3);
        chk("starve_wd", bus.wd, 32'h333);
        chk("starve_clear", {31'd0, bus.stall_req}, 32'd0);

        // Random traffic at three pipeline densities, small rd range for frequent collisions.
        for (int ph = 0; ph < 3; ph++) begin
            int p_pipe;
            p_pipe = (ph == 0) ? 20 : (ph == 1) ? 50 : 92;
            for (int n = 0; n < 700; n++) begin
                if ($urandom_range(0, 399) == 0) begin
                    do_reset();
                end else begin
                    cyc($urandom_range(0, 99) < p_pipe, 5'($urandom_range(0, 10)), $urandom,
                        $urandom_range(0, 99) < 60, 5'($urandom_range(0, 10)), $urandom);
                end
            end
        end

        idle();
        @(negedge clk);
        #1;
        for (int i = 0; i < 32; i++) chk($sformatf("rf_final_x%0d", i), rf[i], m_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
